// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory responder for a single-cycle CPU.
// Decodes each byte address into either a word-addressed data RAM or a small
// MMIO register file. The register file holds a seven-segment data register,
// a free-running cycle counter, and a down-counting timer with sticky status.
// Reads are combinational; writes and counter updates commit on the rising edge.
module dmem_mmio_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter int          RAM_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE = 32'h1001_F000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        DM_ena,
  input  logic        DM_w,
  input  logic        DM_r,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic [31:0] seg_data,
  output logic        tmr_flag,
  output logic        err_flag
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  // Word offsets inside the MMIO window
  localparam logic [2:0] W_SEG    = 3'd0;
  localparam logic [2:0] W_CYCLE  = 3'd1;
  localparam logic [2:0] W_LOAD   = 3'd2;
  localparam logic [2:0] W_CTRL   = 3'd3;
  localparam logic [2:0] W_VAL    = 3'd4;
  localparam logic [2:0] W_STATUS = 3'd5;

  logic [31:0] mem_q [RAM_WORDS];

  logic [31:0] seg_q,   seg_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] load_q,  load_d;
  logic [1:0]  ctrl_q,  ctrl_d;   // bit0 EN, bit1 AUTO
  logic [31:0] val_q,   val_d;
  logic [1:0]  stat_q,  stat_d;   // bit1 ERR, bit0 EXP

  logic [31:0]      ram_off, mmio_off;
  logic             ram_hit, mmio_hit, mmio_ok, aligned, access, bad;
  logic             wr_ram, wr_mmio, rd_en;
  logic [2:0]       mmio_word;
  logic [IDX_W-1:0] ram_idx;

  // Address decode and access classification
  always_comb begin
    ram_off   = DM_addr - RAM_BASE;
    mmio_off  = DM_addr - MMIO_BASE;
    ram_hit   = (DM_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
    mmio_hit  = (DM_addr >= MMIO_BASE) && (mmio_off < 32'h20);
    mmio_word = mmio_off[4:2];
    ram_idx   = ram_off[IDX_W+1:2];
    aligned   = (DM_addr[1:0] == 2'b00);
    // RAM takes precedence if a parameter choice ever makes the windows overlap
    mmio_ok   = mmio_hit && !ram_hit && (mmio_word <= W_STATUS);
    access    = DM_ena && (DM_w || DM_r);
    bad       = access && !(aligned && (ram_hit || mmio_ok));
    wr_ram    = DM_ena && DM_w && !bad && ram_hit;
    wr_mmio   = DM_ena && DM_w && !bad && mmio_ok;
    rd_en     = DM_ena && DM_r && !bad;
  end

  // Zero-latency read mux; reflects pre-write contents during a write cycle
  always_comb begin
    DM_rdata = 32'h0;
    if (rd_en && ram_hit) begin
      DM_rdata = mem_q[ram_idx];
    end else if (rd_en && mmio_ok) begin
      unique case (mmio_word)
        W_SEG:    DM_rdata = seg_q;
        W_CYCLE:  DM_rdata = cycle_q;
        W_LOAD:   DM_rdata = load_q;
        W_CTRL:   DM_rdata = {30'h0, ctrl_q};
        W_VAL:    DM_rdata = val_q;
        W_STATUS: DM_rdata = {30'h0, stat_q};
        default:  DM_rdata = 32'h0;
      endcase
    end
  end

  // Next-state for MMIO registers, timer and sticky status
  always_comb begin
    logic       ctrl_wr;
    logic       exp_set;
    logic [1:0] w1c;

    seg_d   = seg_q;
    cycle_d = cycle_q + 32'd1;
    load_d  = load_q;
    ctrl_d  = ctrl_q;
    val_d   = val_q;
    ctrl_wr = 1'b0;
    exp_set = 1'b0;
    w1c     = 2'b00;

    if (wr_mmio) begin
      unique case (mmio_word)
        W_SEG:    seg_d = DM_wdata;
        W_LOAD:   load_d = DM_wdata;
        W_CTRL: begin
          ctrl_d  = DM_wdata[1:0];
          ctrl_wr = 1'b1;
        end
        W_STATUS: w1c = DM_wdata[1:0];
        default:  ;
      endcase
    end

    // A CTRL write owns this edge: EN=1 restarts from the old TMR_LOAD,
    // EN=0 stops the timer without a final step.
    if (ctrl_wr) begin
      if (DM_wdata[0]) val_d = load_q;
    end else if (ctrl_q[0]) begin
      if (val_q != 32'h0) begin
        val_d = val_q - 32'd1;
      end else begin
        exp_set = 1'b1;
        if (ctrl_q[1]) val_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    // Hardware sets win over a same-edge write-1-to-clear
    stat_d = (stat_q & ~w1c) | {bad, exp_set};
  end

  // MMIO register file, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= 32'h0;
      cycle_q <= 32'h0;
      load_q  <= 32'h0;
      ctrl_q  <= 2'b00;
      val_q   <= 32'h0;
      stat_q  <= 2'b00;
    end else begin
      seg_q   <= seg_d;
      cycle_q <= cycle_d;
      load_q  <= load_d;
      ctrl_q  <= ctrl_d;
      val_q   <= val_d;
      stat_q  <= stat_d;
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_ram) mem_q[ram_idx] <= DM_wdata;
  end

  assign seg_data = seg_q;
  assign tmr_flag = stat_q[0];
  assign err_flag = stat_q[1];

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Testbench for dmem_mmio_responder: directed scenarios followed by random
// traffic, checked through an expected-response queue against a behavioural
// model of the memory map.
module tb_dmem_mmio_responder;

  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'h1001_F000;
  localparam logic [31:0] A_SEG     = MMIO_BASE + 32'h00;
  localparam logic [31:0] A_CYCLE   = MMIO_BASE + 32'h04;
  localparam logic [31:0] A_LOAD    = MMIO_BASE + 32'h08;
  localparam logic [31:0] A_CTRL    = MMIO_BASE + 32'h0C;
  localparam logic [31:0] A_VAL     = MMIO_BASE + 32'h10;
  localparam logic [31:0] A_STATUS  = MMIO_BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        DM_ena, DM_w, DM_r;
  logic [31:0] DM_addr, DM_wdata;
  logic [31:0] DM_rdata, seg_data;
  logic        tmr_flag, err_flag;

  dmem_mmio_responder dut (
    .clk(clk), .rst_n(rst_n), .DM_ena(DM_ena), .DM_w(DM_w), .DM_r(DM_r),
    .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
    .seg_data(seg_data), .tmr_flag(tmr_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
    logic [31:0] seg;
    bit          tmr;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_seg = 0, m_cyc = 0, m_load = 0, m_val = 0;
  logic [1:0]  m_ctrl = 0, m_stat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // 0 = error/unmapped, 1 = RAM word, 2 = assigned MMIO register
  function automatic int region(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 0;
    if (a >= RAM_BASE && a < RAM_BASE + 32'h2000) return 1;
    if (a >= MMIO_BASE && a < MMIO_BASE + 32'h18) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_seg = 0; m_cyc = 0; m_load = 0; m_val = 0; m_ctrl = 0; m_stat = 0;
  endtask

  task automatic model_read(input bit ena, input bit r, input logic [31:0] a,
                            output bit chk, output logic [31:0] v);
    int rg;
    int unsigned k;
    rg  = region(a);
    chk = 1;
    v   = 0;
    if (ena && r && rg == 1) begin
      k = (a - RAM_BASE) / 4;
      if (m_mem.exists(k)) v = m_mem[k];
      else chk = 0;
    end else if (ena && r && rg == 2) begin
      case ((a - MMIO_BASE) / 4)
        0: v = m_seg;
        1: v = m_cyc;
        2: v = m_load;
        3: v = {30'h0, m_ctrl};
        4: v = m_val;
        default: v = {30'h0, m_stat};
      endcase
    end
  endtask

  // Effect of one clock edge on the memory map
  task automatic model_step(input bit ena, input bit w, input bit r,
                            input logic [31:0] a, input logic [31:0] d);
    int          rg;
    logic [31:0] old_load;
    bit          ctrl_wr, exp_set, err_set;
    rg       = region(a);
    err_set  = ena && (w || r) && rg == 0;
    old_load = m_load;
    ctrl_wr  = 0;
    exp_set  = 0;
    m_cyc    = m_cyc + 1;
    if (ena && w && rg == 1) m_mem[(a - RAM_BASE) / 4] = d;
    if (ena && w && rg == 2) begin
      case ((a - MMIO_BASE) / 4)
        0: m_seg = d;
        2: m_load = d;
        3: begin m_ctrl = d[1:0]; ctrl_wr = 1; end
        5: m_stat = m_stat & ~d[1:0];
        default: ;
      endcase
    end
    if (ctrl_wr) begin
      if (m_ctrl[0]) m_val = old_load;
    end else if (m_ctrl[0]) begin
      if (m_val != 0) m_val = m_val - 1;
      else begin
        exp_set = 1;
        if (m_ctrl[1]) m_val = old_load;
        else m_ctrl[0] = 0;
      end
    end
    if (exp_set) m_stat[0] = 1;
    if (err_set) m_stat[1] = 1;
  endtask

  // Apply inputs for the current cycle and queue what the DUT must show
  task automatic drive_now(input bit ena, input bit w, input bit r,
                           input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    DM_ena = ena; DM_w = w; DM_r = r; DM_addr = a; DM_wdata = d;
    model_read(ena, r, a, e.chk_rd, e.rd);
    e.seg = m_seg;
    e.tmr = m_stat[0];
    e.err = m_stat[1];
    exp_q.push_back(e);
    if (rst_n) model_step(ena, w, r, a, d);
  endtask

  task automatic drive(input bit ena, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_now(ena, w, r, a, d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1, 1, 0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1, 0, 1, a, 32'h0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    drive_now(1, 0, 1, A_CYCLE, 32'h0);
  endtask

  // Monitor: one expected entry per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_rd) check("rdata", DM_rdata, e.rd);
      check("seg_data", seg_data, e.seg);
      check("tmr_flag", {31'h0, tmr_flag}, {31'h0, e.tmr});
      check("err_flag", {31'h0, err_flag}, {31'h0, e.err});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          sel;
    rst_n = 1'b1;
    DM_ena = 0; DM_w = 0; DM_r = 0; DM_addr = 0; DM_wdata = 0;
    #2 rst_n = 1'b0;
    reset_pulse();
    reset_pulse();

    // RAM write/read-back and same-cycle read of prior value
    rd(A_CYCLE);
    rd(A_CYCLE);
    wr(RAM_BASE + 4, 32'hAAAA_5555);
    drive(1, 1, 1, RAM_BASE + 4, 32'h1234_5678);
    rd(RAM_BASE + 4);

    // SEG write, ignored write to read-only CYCLE
    wr(A_SEG, 32'hCAFE_0001);
    rd(A_SEG);
    wr(A_CYCLE, 32'h0);
    rd(A_CYCLE);

    // Auto-reload timer, period 4
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < 10; i++) rd(A_VAL);
    rd(A_STATUS);
    wr(A_STATUS, 32'h1);

    // One-shot timer
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) rd(A_VAL);
    rd(A_CTRL);
    rd(A_STATUS);

    // Misaligned read, unmapped write, unassigned offset, then clear ERR
    rd(RAM_BASE + 2);
    wr(32'h2000_0000, 32'hDEAD_BEEF);
    rd(MMIO_BASE + 32'h18);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS);

    // W1C of EXP on an edge that also expires keeps EXP set
    wr(A_LOAD, 32'd0);
    wr(A_CTRL, 32'h3);
    rd(A_VAL);
    wr(A_STATUS, 32'h1);
    rd(A_STATUS);

    // Reset mid-countdown; RAM survives
    wr(A_LOAD, 32'd20);
    wr(A_CTRL, 32'h1);
    rd(A_VAL);
    reset_pulse();
    rd(A_CYCLE);
    rd(A_CYCLE);
    rd(A_VAL);
    rd(RAM_BASE + 4);

    // Random traffic
    for (int n = 0; n < 2500; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       a = RAM_BASE + 32'(4 * $urandom_range(0, 15));
      else if (sel < 8)  a = MMIO_BASE + 32'(4 * $urandom_range(0, 7));
      else if (sel == 8) a = RAM_BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      else begin
        case ($urandom_range(0, 4))
          0: a = 32'h2000_0000;
          1: a = RAM_BASE + 32'h2000;
          2: a = MMIO_BASE - 32'h4;
          3: a = MMIO_BASE + 32'h20;
          default: a = $urandom;
        endcase
      end
      if (a == A_LOAD)        d = 32'($urandom_range(0, 6));
      else if (a == A_STATUS) d = 32'($urandom_range(0, 3));
      else                    d = $urandom;
      if ($urandom_range(0, 199) == 0) reset_pulse();
      else drive($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 4,
                 $urandom_range(0, 1) == 1, a, d);
    end

    drive(0, 0, 0, 32'h0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
